// File: rtl/memory_responder_if.sv
// Request/response bundle between the control FSM (master) and the unified memory (slave).
// Signal names follow the multi-cycle datapath they plug into.
interface memory_responder_if;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] memory_data;
   logic        mem_ready;
   logic        mem_busy;
   logic        mem_err;

   modport master (
      output MemRead, MemWrite, address, write_data,
      input  memory_data, mem_ready, mem_busy, mem_err
   );

   modport slave (
      input  MemRead, MemWrite, address, write_data,
      output memory_data, mem_ready, mem_busy, mem_err
   );
endinterface

// File: rtl/memory_responder.sv
// Word-organised unified instruction/data memory with fixed access latency.
// One request in flight at a time; completion is a single-cycle mem_ready pulse.
module memory_responder #(
   parameter int ADDR_WIDTH = 8,
   parameter int LATENCY    = 2
) (
   input  logic              clk,
   input  logic              reset,
   memory_responder_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   // Misaligned byte address, or a word beyond the storage depth.
   function automatic logic addr_fault(input logic [31:0] addr);
      return (addr[1:0] != 2'b00) || ((addr >> (ADDR_WIDTH + 2)) != 32'd0);
   endfunction

   state_t                  state_r;
   logic [3:0]              count_r;
   logic [ADDR_WIDTH-1:0]   word_r;
   logic [31:0]             wdata_r;
   logic                    write_r;
   logic                    err_r;
   logic [31:0]             mem_r [DEPTH];

   logic                    request_s;
   logic                    commit_s;
   logic                    store_s;
   logic [31:0]             rdata_s;

   // Decode request presence, the completion edge and the storage port.
   always_comb begin
      request_s = bus.MemRead | bus.MemWrite;
      commit_s  = (state_r == WAIT) && (count_r == 4'd0);
      store_s   = commit_s && write_r && !err_r;
      rdata_s   = mem_r[word_r];
   end

   // Storage array; deliberately not reset so contents survive a reset pulse.
   always_ff @(posedge clk) begin
      if (store_s) begin
         mem_r[word_r] <= wdata_r;
      end
   end

   // Request FSM with registered handshake outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r         <= IDLE;
         count_r         <= 4'd0;
         word_r          <= {ADDR_WIDTH{1'b0}};
         wdata_r         <= 32'd0;
         write_r         <= 1'b0;
         err_r           <= 1'b0;
         bus.memory_data <= 32'd0;
         bus.mem_ready   <= 1'b0;
         bus.mem_busy    <= 1'b0;
         bus.mem_err     <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (request_s) begin
                  // Everything needed later is captured here; the bus may change freely during WAIT.
                  word_r       <= bus.address[ADDR_WIDTH+1:2];
                  wdata_r      <= bus.write_data;
                  write_r      <= bus.MemWrite;
                  err_r        <= (bus.MemRead & bus.MemWrite) | addr_fault(bus.address);
                  count_r      <= 4'(LATENCY - 1);
                  bus.mem_busy <= 1'b1;
                  state_r      <= WAIT;
               end else begin
                  state_r      <= IDLE;
               end
            end
            WAIT: begin
               if (count_r != 4'd0) begin
                  count_r <= count_r - 4'd1;
               end else begin
                  if (!write_r && !err_r) begin
                     bus.memory_data <= rdata_s;
                  end else begin
                     bus.memory_data <= bus.memory_data;
                  end
                  bus.mem_busy  <= 1'b0;
                  bus.mem_ready <= 1'b1;
                  bus.mem_err   <= err_r;
                  state_r       <= DONE;
               end
            end
            DONE: begin
               bus.mem_ready <= 1'b0;
               bus.mem_err   <= 1'b0;
               state_r       <= IDLE;
            end
            default: begin
               bus.mem_ready <= 1'b0;
               bus.mem_busy  <= 1'b0;
               bus.mem_err   <= 1'b0;
               count_r       <= 4'd0;
               state_r       <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: directed vector table, reset-abort and streaming sequences,
// and randomized traffic checked against an array-based reference model.
module tb_memory_responder;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   memory_responder_if bus();
   memory_responder_if bus_l1();
   memory_responder_if bus_l3();

   memory_responder #(.ADDR_WIDTH(8), .LATENCY(2)) dut    (.clk(clk), .reset(reset), .bus(bus));
   memory_responder #(.ADDR_WIDTH(8), .LATENCY(1)) dut_l1 (.clk(clk), .reset(reset), .bus(bus_l1));
   memory_responder #(.ADDR_WIDTH(8), .LATENCY(3)) dut_l3 (.clk(clk), .reset(reset), .bus(bus_l3));

   // Side instances (latency 1 and 3) are driven from these, index 0 -> L1, 1 -> L3.
   logic [1:0]  s_rd;
   logic [1:0]  s_wr;
   logic [31:0] s_addr [2];
   logic [31:0] s_wd   [2];
   wire  [1:0]  s_ready = {bus_l3.mem_ready, bus_l1.mem_ready};
   wire  [1:0]  s_busy  = {bus_l3.mem_busy,  bus_l1.mem_busy};
   wire  [1:0]  s_err   = {bus_l3.mem_err,   bus_l1.mem_err};
   wire  [31:0] s_q0    = bus_l1.memory_data;
   wire  [31:0] s_q1    = bus_l3.memory_data;

   assign bus_l1.MemRead    = s_rd[0];
   assign bus_l1.MemWrite   = s_wr[0];
   assign bus_l1.address    = s_addr[0];
   assign bus_l1.write_data = s_wd[0];
   assign bus_l3.MemRead    = s_rd[1];
   assign bus_l3.MemWrite   = s_wr[1];
   assign bus_l3.address    = s_addr[1];
   assign bus_l3.write_data = s_wd[1];

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic        err;
      logic [31:0] q;
   } vec_t;

   vec_t vecs [14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One request on the main bus; returns edges from acceptance to mem_ready, plus data/err.
   task automatic transact(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                           output int lat, output logic [31:0] q, output logic e);
      lat = -1;
      q   = 32'd0;
      e   = 1'b0;
      @(negedge clk);
      bus.MemRead    = rd;
      bus.MemWrite   = wr;
      bus.address    = a;
      bus.write_data = d;
      @(posedge clk);
      @(negedge clk);
      bus.MemRead    = 1'b0;
      bus.MemWrite   = 1'b0;
      bus.address    = $urandom;
      bus.write_data = $urandom;
      chk("accept_busy", {31'd0, bus.mem_busy}, 32'd1);
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (bus.mem_ready) begin
            lat = i;
            q   = bus.memory_data;
            e   = bus.mem_err;
            break;
         end
      end
      if (lat > 0) begin
         @(negedge clk);
         chk("pulse_end", {29'd0, bus.mem_ready, bus.mem_busy, bus.mem_err}, 32'd0);
      end
   endtask

   task automatic side_write(input int k, input logic [31:0] a, input logic [31:0] d);
      int n;
      @(negedge clk);
      s_wr[k]   = 1'b1;
      s_addr[k] = a;
      s_wd[k]   = d;
      @(posedge clk);
      @(negedge clk);
      s_wr[k] = 1'b0;
      n = 0;
      while (!s_ready[k] && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("side_wr_done", {31'd0, s_ready[k]}, 32'd1);
      @(negedge clk);
   endtask

   // MemRead held high; address is moved to a decoy word whenever the DUT reports busy.
   task automatic side_stream(input int k, input int lat_p);
      logic [31:0] v1;
      logic [31:0] q;
      int          prev;
      int          npulse;
      v1 = 32'hC0DE0000 | 32'(lat_p);
      side_write(k, 32'h40, v1);
      side_write(k, 32'h44, ~v1);
      @(negedge clk);
      s_addr[k] = 32'h40;
      s_rd[k]   = 1'b1;
      prev   = -1;
      npulse = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (s_ready[k]) begin
            q = (k == 0) ? s_q0 : s_q1;
            chk("side_data", q, v1);
            chk("side_err", {31'd0, s_err[k]}, 32'd0);
            // accept edge, LATENCY edges to completion, then the DONE cycle
            if (prev >= 0) chk("side_period", 32'(c - prev), 32'(lat_p + 2));
            prev = c;
            npulse++;
         end
         s_addr[k] = s_busy[k] ? 32'h44 : 32'h40;
      end
      s_rd[k] = 1'b0;
      chk("side_pulses", {31'd0, npulse >= 5}, 32'd1);
      repeat (lat_p + 3) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int          lat;
      logic [31:0] q;
      logic        e;
      logic [31:0] ref_mem [8];
      logic [31:0] ref_q;
      logic        exp_err;
      logic        rd;
      logic        wr;
      logic [31:0] a;
      logic [31:0] d;
      int          kind;
      int          w;

      vecs[0]  = '{1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0};
      vecs[1]  = '{1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF};
      vecs[2]  = '{1'b1, 1'b0, 32'h13,  32'h0,        1'b1, 32'hDEADBEEF};
      vecs[3]  = '{1'b1, 1'b0, 32'h400, 32'h0,        1'b1, 32'hDEADBEEF};
      vecs[4]  = '{1'b1, 1'b1, 32'h10,  32'h0,        1'b1, 32'hDEADBEEF};
      vecs[5]  = '{1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF};
      vecs[6]  = '{1'b0, 1'b1, 32'h3FC, 32'hA5A50001, 1'b0, 32'hDEADBEEF};
      vecs[7]  = '{1'b1, 1'b0, 32'h3FC, 32'h0,        1'b0, 32'hA5A50001};
      vecs[8]  = '{1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF};
      vecs[9]  = '{1'b0, 1'b1, 32'h13,  32'h0,        1'b1, 32'hDEADBEEF};
      vecs[10] = '{1'b0, 1'b1, 32'h410, 32'h0,        1'b1, 32'hDEADBEEF};
      vecs[11] = '{1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF};
      vecs[12] = '{1'b1, 1'b0, 32'h3FC, 32'h0,        1'b0, 32'hA5A50001};
      vecs[13] = '{1'b0, 1'b1, 32'h20,  32'h0BADF00D, 1'b0, 32'hA5A50001};

      reset          = 1'b0;
      bus.MemRead    = 1'b0;
      bus.MemWrite   = 1'b0;
      bus.address    = 32'd0;
      bus.write_data = 32'd0;
      s_rd           = 2'b00;
      s_wr           = 2'b00;
      s_addr[0]      = 32'd0;
      s_addr[1]      = 32'd0;
      s_wd[0]        = 32'd0;
      s_wd[1]        = 32'd0;

      // Reset state, then idle with no requests.
      repeat (2) @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle_data", bus.memory_data, 32'd0);
         chk("idle_flags", {29'd0, bus.mem_ready, bus.mem_busy, bus.mem_err}, 32'd0);
      end

      // Directed vector table.
      for (int i = 0; i < 14; i++) begin
         transact(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, lat, q, e);
         chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd2);
         chk($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, vecs[i].err});
         chk($sformatf("vec%0d_data", i), q, vecs[i].q);
      end

      // Reset one cycle after a write is accepted: outputs clear at once, write never lands.
      @(negedge clk);
      bus.MemWrite   = 1'b1;
      bus.address    = 32'h20;
      bus.write_data = 32'h12345678;
      @(posedge clk);
      @(negedge clk);
      bus.MemWrite = 1'b0;
      chk("abort_busy", {31'd0, bus.mem_busy}, 32'd1);
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("abort_rst_data", bus.memory_data, 32'd0);
      chk("abort_rst_flags", {29'd0, bus.mem_ready, bus.mem_busy, bus.mem_err}, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      transact(1'b1, 1'b0, 32'h20, 32'd0, lat, q, e);
      chk("abort_rd_lat", 32'(lat), 32'd2);
      chk("abort_rd_err", {31'd0, e}, 32'd0);
      chk("abort_rd_data", q, 32'h0BADF00D);

      // Back-to-back reads at latency 1 and 3.
      side_stream(0, 1);
      side_stream(1, 3);

      // Randomized traffic against a word-array model over words 0..7.
      ref_q = 32'h0BADF00D;
      for (int i = 0; i < 8; i++) begin
         d = $urandom;
         transact(1'b0, 1'b1, 32'(i * 4), d, lat, q, e);
         chk("init_lat", 32'(lat), 32'd2);
         chk("init_err", {31'd0, e}, 32'd0);
         chk("init_data", q, ref_q);
         ref_mem[i] = d;
      end
      for (int n = 0; n < 150; n++) begin
         kind = $urandom_range(0, 9);
         w    = $urandom_range(0, 7);
         d    = $urandom;
         a    = 32'(w * 4);
         if (kind <= 3) begin
            rd = 1'b1; wr = 1'b0;
         end else if (kind <= 6) begin
            rd = 1'b0; wr = 1'b1;
         end else if (kind == 7) begin
            rd = 1'b1; wr = 1'b1;
         end else begin
            rd = 1'($urandom_range(0, 1));
            wr = !rd;
         end
         if (kind == 8) a = a + 32'($urandom_range(1, 3));
         if (kind == 9) a = a | (32'd1 << $urandom_range(10, 31));

         exp_err = (rd && wr) || (a % 4 != 0) || (a >= 32'd1024);
         if (!exp_err) begin
            if (wr) ref_mem[a[4:2]] = d;
            else    ref_q = ref_mem[a[4:2]];
         end

         transact(rd, wr, a, d, lat, q, e);
         chk("rand_lat", 32'(lat), 32'd2);
         chk("rand_err", {31'd0, e}, {31'd0, exp_err});
         chk("rand_data", q, ref_q);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
